// File: rtl/fft_frame_buffer.sv
// Ping-pong complex frame buffer: streams samples in one per clock and presents whole frames as flat buses.
// Optional macro FFT_FRAME_BITREV_EN presents each frame in bit-reversed element order.
module fft_frame_buffer #(
    parameter int N     = 16,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_re,
    input  logic [WIDTH-1:0]     in_im,
    input  logic                 in_last,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic [N*WIDTH-1:0]   frame_re,
    output logic [N*WIDTH-1:0]   frame_im,
    output logic [AW:0]          frame_len,
    output logic                 short_frame,
    output logic [15:0]          drop_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [AW:0]   LEN_ONE   = {{AW{1'b0}}, 1'b1};

    logic               wr_bank_r;
    logic               rd_bank_r;
    logic [AW-1:0]      wr_addr_r;
    logic [1:0]         full_r;
    logic [1:0]         short_r;
    logic [AW:0]        len_r [2];
    logic [15:0]        drop_cnt_r;

    logic [WIDTH-1:0]   mem_re [2*N];
    logic [WIDTH-1:0]   mem_im [2*N];

    logic               accept_s;
    logic               close_s;
    logic               consume_s;
    logic               drop_s;
    logic [1:0]         full_nxt_s;
    logic [AW:0]        cur_len_s;
    logic [N*WIDTH-1:0] frame_re_s;
    logic [N*WIDTH-1:0] frame_im_s;

`ifdef FFT_FRAME_BITREV_EN
    function automatic logic [AW-1:0] elem_idx(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = k[AW-1-b];
        end
        return r;
    endfunction
`else
    function automatic logic [AW-1:0] elem_idx(input logic [AW-1:0] k);
        return k;
    endfunction
`endif

    assign in_ready    = ~full_r[wr_bank_r];
    assign frame_valid = full_r[rd_bank_r];
    assign accept_s    = in_valid & ~full_r[wr_bank_r];
    assign close_s     = accept_s & ((wr_addr_r == LAST_ADDR) | in_last);
    assign consume_s   = full_r[rd_bank_r] & frame_ready;
    assign drop_s      = in_valid & full_r[wr_bank_r];
    assign cur_len_s   = len_r[rd_bank_r];

    // Next bank-full flags: writer closes one bank while the reader may free the other on the same edge.
    always_comb begin
        full_nxt_s = full_r;
        if (consume_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s = full_nxt_s;
        end
        if (close_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s = full_nxt_s;
        end
    end

    // Control state: bank pointers, write address, full/length/short flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            wr_addr_r <= '0;
            full_r    <= 2'b00;
            short_r   <= 2'b00;
            len_r[0]  <= '0;
            len_r[1]  <= '0;
        end else begin
            full_r <= full_nxt_s;
            if (consume_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
            if (close_s) begin
                len_r[wr_bank_r]   <= {1'b0, wr_addr_r} + LEN_ONE;
                short_r[wr_bank_r] <= (wr_addr_r != LAST_ADDR);
                wr_bank_r          <= ~wr_bank_r;
                wr_addr_r          <= '0;
            end else if (accept_s) begin
                wr_addr_r <= wr_addr_r + AW'(1);
            end
        end
    end

    // Saturating count of samples offered while both banks were full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_re[{wr_bank_r, wr_addr_r}] <= in_re;
            mem_im[{wr_bank_r, wr_addr_r}] <= in_im;
        end
    end

    // Output mux: positions beyond the written length read as zero so short frames arrive padded.
    always_comb begin
        frame_re_s = '0;
        frame_im_s = '0;
        for (int k = 0; k < N; k++) begin
            if (full_r[rd_bank_r] && ({1'b0, elem_idx(AW'(k))} < cur_len_s)) begin
                frame_re_s[k*WIDTH +: WIDTH] = mem_re[{rd_bank_r, elem_idx(AW'(k))}];
                frame_im_s[k*WIDTH +: WIDTH] = mem_im[{rd_bank_r, elem_idx(AW'(k))}];
            end else begin
                frame_re_s[k*WIDTH +: WIDTH] = '0;
                frame_im_s[k*WIDTH +: WIDTH] = '0;
            end
        end
    end

    assign frame_re    = frame_re_s;
    assign frame_im    = frame_im_s;
    assign frame_len   = full_r[rd_bank_r] ? cur_len_s : '0;
    assign short_frame = full_r[rd_bank_r] & short_r[rd_bank_r];
    assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer: stimulus queues expected frames, a negedge monitor checks consumed frames.
module tb_fft_frame_buffer;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int AW = 4;

    typedef struct packed {
        logic [N*W-1:0] re;
        logic [N*W-1:0] im;
        logic [AW:0]    len;
        logic           short_f;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_re;
    logic [W-1:0]   in_im;
    logic           in_last;
    logic           frame_valid;
    logic           frame_ready;
    logic [N*W-1:0] frame_re;
    logic [N*W-1:0] frame_im;
    logic [AW:0]    frame_len;
    logic           short_frame;
    logic [15:0]    drop_cnt;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_stream = 1'b0;

    fft_frame_buffer #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_re(frame_re), .frame_im(frame_im), .frame_len(frame_len),
        .short_frame(short_frame), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int tb_idx(input int k);
`ifdef FFT_FRAME_BITREV_EN
        int r = 0;
        for (int b = 0; b < AW; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
        end
        return r;
`else
        return k;
`endif
    endfunction

    // Drive one frame, one sample per cycle; push the expected frame when it should be accepted.
    task automatic send_frame(input int br, input int sr, input int bi, input int si,
                              input int n, input bit lst, input bit acc);
        logic [W-1:0] sre [N];
        logic [W-1:0] sim [N];
        exp_t e;
        for (int i = 0; i < N; i++) begin
            sre[i] = W'(br + sr * i);
            sim[i] = W'(bi + si * i);
        end
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_re    = sre[i];
            in_im    = sim[i];
            in_last  = lst && (i == n - 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (acc) begin
            e.len     = (AW+1)'(n);
            e.short_f = (n != N);
            for (int k = 0; k < N; k++) begin
                e.re[k*W +: W] = (tb_idx(k) < n) ? sre[tb_idx(k)] : '0;
                e.im[k*W +: W] = (tb_idx(k) < n) ? sim[tb_idx(k)] : '0;
            end
            q.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
    endtask

    // Monitor: every frame handed downstream must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst && chk_stream) check("in_ready_stream", in_ready, 1);
        if (rst && frame_valid && frame_ready) begin
            if (q.size() == 0) begin
                check("unexpected_frame", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("frame_re", frame_re, e.re);
                check("frame_im", frame_im, e.im);
                check("frame_len", frame_len, e.len);
                check("short_frame", short_frame, e.short_f);
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0; frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_re", frame_re, 0);
        check("rst_frame_im", frame_im, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_short", short_frame, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Frame A: re=100*i, im=-i, held until released
        send_frame(0, 100, 0, -1, N, 1'b0, 1'b1);
        @(negedge clk);
        check("a_latency_valid", frame_valid, 1);
        check("a_elem5_re", frame_re[5*W +: W], 16'd500);
        check("a_elem5_im", frame_im[5*W +: W], 16'hFFFB);
        check("a_len", frame_len, 16);
        check("a_short", short_frame, 0);
        check("a_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Frame B fills the second bank, frame C is dropped
        send_frame(1000, 1, 0, 1, N, 1'b1, 1'b1);
        @(negedge clk);
        check("both_full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        send_frame(7, 3, 9, 1, N, 1'b1, 1'b0);
        @(negedge clk);
        check("drop_cnt_16", drop_cnt, 16);
        check("drop_in_ready", in_ready, 0);
        @(posedge clk); #1;
        frame_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_consume", in_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("both_consumed", frame_valid, 0);
        @(posedge clk); #1;
        frame_ready = 1'b0;

        // Short frame: re=1..6 closed by in_last on the 6th sample
        send_frame(1, 1, -1, -1, 6, 1'b1, 1'b1);
        @(negedge clk);
        check("short_len", frame_len, 6);
        check("short_flag", short_frame, 1);
        check("short_pad_re6", frame_re[6*W +: W], 0);
        @(posedge clk); #1;
        frame_ready = 1'b1;
        drain(10);

        // Continuous streaming, 8 frames back-to-back
        chk_stream = 1'b1;
        for (int f = 0; f < 8; f++) send_frame(f * 16, 1, -f, 0, N, 1'b0, 1'b1);
        chk_stream = 1'b0;
        drain(10);

        // Reset with one bank full and 8 samples in the other
        frame_ready = 1'b0;
        @(posedge clk); #1;
        send_frame(50, 2, 3, 0, N, 1'b0, 1'b0);
        send_frame(60, 1, 4, 0, 8, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_frame_re", frame_re, 0);
        check("mid_rst_len", frame_len, 0);
        check("mid_rst_drop", drop_cnt, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        send_frame(-20, 5, 11, -3, N, 1'b1, 1'b1);
        @(negedge clk);
        check("post_rst_valid", frame_valid, 1);
        @(posedge clk); #1;
        frame_ready = 1'b1;
        drain(10);

        // Element order check with re=i
        frame_ready = 1'b0;
        send_frame(0, 1, 0, 0, N, 1'b0, 1'b1);
        @(negedge clk);
`ifdef FFT_FRAME_BITREV_EN
        check("order_elem1", frame_re[1*W +: W], 8);
        check("order_elem3", frame_re[3*W +: W], 12);
        check("order_elem15", frame_re[15*W +: W], 15);
`else
        check("order_elem1", frame_re[1*W +: W], 1);
        check("order_elem3", frame_re[3*W +: W], 3);
        check("order_elem15", frame_re[15*W +: W], 15);
`endif
        @(posedge clk); #1;
        frame_ready = 1'b1;
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
